// File: rtl/sync_fifo_if.sv
// Handshake and status bundle between a single-clock FIFO and its producer/consumer.
// master drives requests, data and thresholds; slave (the FIFO) returns data and status.
interface sync_fifo_if #(
  parameter int DSIZE = 32,
  parameter int ASIZE = 4
);
  logic             flush;
  logic             winc;
  logic [DSIZE-1:0] wdata;
  logic             wfull;
  logic             awfull;
  logic [ASIZE-1:0] awfull_th;
  logic             rinc;
  logic [DSIZE-1:0] rdata;
  logic             rempty;
  logic             arempty;
  logic [ASIZE-1:0] arempty_th;
  logic [ASIZE:0]   fill;
  logic             overflow;
  logic             underflow;

  modport master (
    output flush, winc, wdata, awfull_th, rinc, arempty_th,
    input  wfull, awfull, rdata, rempty, arempty, fill, overflow, underflow
  );

  modport slave (
    input  flush, winc, wdata, awfull_th, rinc, arempty_th,
    output wfull, awfull, rdata, rempty, arempty, fill, overflow, underflow
  );
endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with programmable almost flags, fill level, flush and sticky errors.
// Status is registered (1 cycle); rdata is fall-through or 1-cycle registered; full rejects writes, empty rejects reads.
module sync_fifo #(
  parameter int DSIZE       = 32,
  parameter int ASIZE       = 4,
  parameter     FALLTHROUGH = "TRUE"
) (
  input logic        clk,
  input logic        rst_n,
  sync_fifo_if.slave bus
);
  localparam int             DEPTH   = 1 << ASIZE;
  localparam logic [ASIZE:0] DEPTH_V = {1'b1, {ASIZE{1'b0}}};

  logic [DSIZE-1:0] mem [DEPTH];
  logic [ASIZE:0]   wptr, rptr;
  logic [ASIZE:0]   fill_q, fill_nxt;
  logic             wfull_q, rempty_q, awfull_q, arempty_q;
  logic             overflow_q, underflow_q;
  logic             wr_acc, rd_acc;

  // Acceptance is judged on the registered flags seen before the edge.
  always_comb begin
    wr_acc   = bus.winc && !wfull_q  && !bus.flush;
    rd_acc   = bus.rinc && !rempty_q && !bus.flush;
    fill_nxt = fill_q;
    case ({wr_acc, rd_acc})
      2'b10:   fill_nxt = fill_q + 1'b1;
      2'b01:   fill_nxt = fill_q - 1'b1;
      default: fill_nxt = fill_q;
    endcase
    if (bus.flush) fill_nxt = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
    end else if (bus.flush) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (wr_acc) wptr <= wptr + 1'b1;
      if (rd_acc) rptr <= rptr + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fill_q    <= '0;
      wfull_q   <= 1'b0;
      rempty_q  <= 1'b1;
      awfull_q  <= 1'b0;
      arempty_q <= 1'b0;
    end else begin
      fill_q    <= fill_nxt;
      wfull_q   <= (fill_nxt == DEPTH_V);
      rempty_q  <= (fill_nxt == '0);
      awfull_q  <= (fill_nxt >= (DEPTH_V - {1'b0, bus.awfull_th}));
      arempty_q <= (fill_nxt != '0) && (fill_nxt <= {1'b0, bus.arempty_th});
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else if (bus.flush) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (bus.winc && wfull_q)  overflow_q  <= 1'b1;
      if (bus.rinc && rempty_q) underflow_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_acc) mem[wptr[ASIZE-1:0]] <= bus.wdata;
  end

  generate
    if (FALLTHROUGH == "TRUE") begin : g_fwft
      assign bus.rdata = mem[rptr[ASIZE-1:0]];
    end else begin : g_reg
      logic [DSIZE-1:0] rdata_q;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)         rdata_q <= '0;
        else if (bus.flush) rdata_q <= '0;
        else if (rd_acc)    rdata_q <= mem[rptr[ASIZE-1:0]];
      end
      assign bus.rdata = rdata_q;
    end
  endgenerate

  assign bus.fill      = fill_q;
  assign bus.wfull     = wfull_q;
  assign bus.rempty    = rempty_q;
  assign bus.awfull    = awfull_q;
  assign bus.arempty   = arempty_q;
  assign bus.overflow  = overflow_q;
  assign bus.underflow = underflow_q;
endmodule

// File: tb/tb_sync_fifo.sv
// Directed bench driving a fall-through and a registered-read FIFO with identical stimulus.
module tb_sync_fifo;
  localparam int DSIZE = 32;
  localparam int ASIZE = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             flush = 1'b0;
  logic             winc = 1'b0;
  logic             rinc = 1'b0;
  logic [DSIZE-1:0] wdata = '0;
  logic [ASIZE-1:0] awth = '0;
  logic [ASIZE-1:0] aeth = '0;
  int               checks = 0;
  int               failures = 0;

  always #5 clk = ~clk;

  sync_fifo_if #(.DSIZE(DSIZE), .ASIZE(ASIZE)) bt ();
  sync_fifo_if #(.DSIZE(DSIZE), .ASIZE(ASIZE)) bf ();

  assign bt.flush = flush;  assign bf.flush = flush;
  assign bt.winc  = winc;   assign bf.winc  = winc;
  assign bt.wdata = wdata;  assign bf.wdata = wdata;
  assign bt.rinc  = rinc;   assign bf.rinc  = rinc;
  assign bt.awfull_th  = awth;  assign bf.awfull_th  = awth;
  assign bt.arempty_th = aeth;  assign bf.arempty_th = aeth;

  sync_fifo #(.DSIZE(DSIZE), .ASIZE(ASIZE), .FALLTHROUGH("TRUE"))  u_ft (.clk(clk), .rst_n(rst_n), .bus(bt));
  sync_fifo #(.DSIZE(DSIZE), .ASIZE(ASIZE), .FALLTHROUGH("FALSE")) u_rg (.clk(clk), .rst_n(rst_n), .bus(bf));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_flush();
    flush = 1'b1; tick(); flush = 1'b0;
  endtask

  task automatic write_n(input int n, input int base);
    for (int i = 0; i < n; i++) begin
      winc = 1'b1; wdata = base + i; tick();
    end
    winc = 1'b0;
  endtask

  task automatic test_reset();
    checks++; if (bt.rempty !== 1'b1) begin failures++; $display("FAIL reset_rempty got=%b exp=1", bt.rempty); end
    checks++; if (bt.wfull !== 1'b0) begin failures++; $display("FAIL reset_wfull got=%b exp=0", bt.wfull); end
    checks++; if (bt.awfull !== 1'b0 || bt.arempty !== 1'b0) begin failures++; $display("FAIL reset_almost got=%b%b exp=00", bt.awfull, bt.arempty); end
    checks++; if (bt.fill !== 5'd0) begin failures++; $display("FAIL reset_fill got=%0d exp=0", bt.fill); end
    checks++; if (bt.overflow !== 1'b0 || bt.underflow !== 1'b0) begin failures++; $display("FAIL reset_err got=%b%b exp=00", bt.overflow, bt.underflow); end
    checks++; if (bf.rdata !== 32'd0) begin failures++; $display("FAIL reset_rdata got=%0h exp=0", bf.rdata); end
  endtask

  task automatic test_stream();
    winc = 1'b1; wdata = 0; tick();
    checks++; if (bt.rempty !== 1'b0 || bt.fill !== 5'd1) begin failures++; $display("FAIL stream_first got=rempty%b fill%0d exp=rempty0 fill1", bt.rempty, bt.fill); end
    write_n(9, 1);
    checks++; if (bt.fill !== 5'd10) begin failures++; $display("FAIL stream_fill10 got=%0d exp=10", bt.fill); end
    for (int i = 0; i < 10; i++) begin
      rinc = 1'b1;
      checks++; if (bt.rdata !== 32'(i)) begin failures++; $display("FAIL stream_ft_data[%0d] got=%0h exp=%0h", i, bt.rdata, i); end
      tick();
      checks++; if (bf.rdata !== 32'(i)) begin failures++; $display("FAIL stream_reg_data[%0d] got=%0h exp=%0h", i, bf.rdata, i); end
    end
    rinc = 1'b0;
    checks++; if (bt.fill !== 5'd0 || bt.rempty !== 1'b1) begin failures++; $display("FAIL stream_drain got=fill%0d rempty%b exp=fill0 rempty1", bt.fill, bt.rempty); end
  endtask

  task automatic test_full();
    write_n(16, 0);
    checks++; if (bt.wfull !== 1'b1 || bt.fill !== 5'd16) begin failures++; $display("FAIL full_16 got=wfull%b fill%0d exp=wfull1 fill16", bt.wfull, bt.fill); end
    checks++; if (bt.awfull !== 1'b1) begin failures++; $display("FAIL full_awfull_th0 got=%b exp=1", bt.awfull); end
    checks++; if (bt.overflow !== 1'b0) begin failures++; $display("FAIL full_no_ovf_yet got=%b exp=0", bt.overflow); end
    winc = 1'b1; wdata = 32'h999; tick(); winc = 1'b0;
    checks++; if (bt.fill !== 5'd16 || bt.overflow !== 1'b1) begin failures++; $display("FAIL full_17th got=fill%0d ovf%b exp=fill16 ovf1", bt.fill, bt.overflow); end
    winc = 1'b1; rinc = 1'b1; wdata = 32'h555;
    checks++; if (bt.rdata !== 32'd0) begin failures++; $display("FAIL full_wr_rd_ft got=%0h exp=0", bt.rdata); end
    tick(); winc = 1'b0; rinc = 1'b0;
    checks++; if (bt.fill !== 5'd15 || bt.wfull !== 1'b0) begin failures++; $display("FAIL full_wr_rd_fill got=fill%0d wfull%b exp=fill15 wfull0", bt.fill, bt.wfull); end
    checks++; if (bf.rdata !== 32'd0) begin failures++; $display("FAIL full_wr_rd_reg got=%0h exp=0", bf.rdata); end
    checks++; if (bt.rdata !== 32'd1) begin failures++; $display("FAIL full_next_head got=%0h exp=1", bt.rdata); end
    do_flush();
  endtask

  task automatic test_thresholds();
    awth = 4'd3; aeth = 4'd2; tick();
    for (int k = 1; k <= 13; k++) begin
      winc = 1'b1; wdata = 32'h100 + k; tick();
      if (k == 2) begin checks++; if (bt.arempty !== 1'b1) begin failures++; $display("FAIL th_arempty_at2 got=%b exp=1", bt.arempty); end end
      if (k == 3) begin checks++; if (bt.arempty !== 1'b0) begin failures++; $display("FAIL th_arempty_at3 got=%b exp=0", bt.arempty); end end
      if (k == 12) begin checks++; if (bt.awfull !== 1'b0) begin failures++; $display("FAIL th_awfull_at12 got=%b exp=0", bt.awfull); end end
      if (k == 13) begin checks++; if (bt.awfull !== 1'b1) begin failures++; $display("FAIL th_awfull_at13 got=%b exp=1", bt.awfull); end end
    end
    winc = 1'b0; rinc = 1'b1; tick(); rinc = 1'b0;
    checks++; if (bt.awfull !== 1'b0 || bt.fill !== 5'd12) begin failures++; $display("FAIL th_awfull_drop got=awfull%b fill%0d exp=awfull0 fill12", bt.awfull, bt.fill); end
    do_flush(); awth = '0; aeth = '0; tick();
  endtask

  task automatic test_underflow();
    rinc = 1'b1; tick(); rinc = 1'b0;
    checks++; if (bt.underflow !== 1'b1 || bt.fill !== 5'd0) begin failures++; $display("FAIL uf_alone got=uf%b fill%0d exp=uf1 fill0", bt.underflow, bt.fill); end
    do_flush();
    checks++; if (bt.underflow !== 1'b0) begin failures++; $display("FAIL uf_flush_clear got=%b exp=0", bt.underflow); end
    winc = 1'b1; rinc = 1'b1; wdata = 32'h77; tick(); winc = 1'b0; rinc = 1'b0;
    checks++; if (bt.underflow !== 1'b1 || bt.fill !== 5'd1 || bt.rempty !== 1'b0) begin failures++; $display("FAIL uf_with_write got=uf%b fill%0d rempty%b exp=uf1 fill1 rempty0", bt.underflow, bt.fill, bt.rempty); end
    checks++; if (bt.rdata !== 32'h77 || bf.rdata !== 32'd0) begin failures++; $display("FAIL uf_data got=ft%0h reg%0h exp=ft77 reg0", bt.rdata, bf.rdata); end
    do_flush();
  endtask

  task automatic test_flush();
    write_n(17, 0);
    for (int i = 0; i < 8; i++) begin rinc = 1'b1; tick(); end
    rinc = 1'b0;
    checks++; if (bt.fill !== 5'd8 || bt.overflow !== 1'b1) begin failures++; $display("FAIL fl_pre got=fill%0d ovf%b exp=fill8 ovf1", bt.fill, bt.overflow); end
    flush = 1'b1; winc = 1'b1; wdata = 32'h55; tick(); flush = 1'b0; winc = 1'b0;
    checks++; if (bt.fill !== 5'd0 || bt.rempty !== 1'b1 || bt.overflow !== 1'b0) begin failures++; $display("FAIL fl_state got=fill%0d rempty%b ovf%b exp=fill0 rempty1 ovf0", bt.fill, bt.rempty, bt.overflow); end
    checks++; if (bf.rdata !== 32'd0 || bt.wfull !== 1'b0) begin failures++; $display("FAIL fl_rdata got=reg%0h wfull%b exp=reg0 wfull0", bf.rdata, bt.wfull); end
    winc = 1'b1; wdata = 32'hA; tick(); winc = 1'b0;
    rinc = 1'b1;
    checks++; if (bt.rdata !== 32'hA) begin failures++; $display("FAIL fl_after_ft got=%0h exp=a", bt.rdata); end
    tick(); rinc = 1'b0;
    checks++; if (bf.rdata !== 32'hA || bt.fill !== 5'd0) begin failures++; $display("FAIL fl_after_reg got=%0h fill%0d exp=a fill0", bf.rdata, bt.fill); end
  endtask

  task automatic test_async_reset();
    write_n(17, 32'h200);
    checks++; if (bt.overflow !== 1'b1) begin failures++; $display("FAIL ar_pre_ovf got=%b exp=1", bt.overflow); end
    winc = 1'b1; wdata = 32'h300;
    #3 rst_n = 1'b0;
    #1;
    checks++; if (bt.fill !== 5'd0 || bt.rempty !== 1'b1 || bt.wfull !== 1'b0) begin failures++; $display("FAIL ar_state got=fill%0d rempty%b wfull%b exp=fill0 rempty1 wfull0", bt.fill, bt.rempty, bt.wfull); end
    checks++; if (bt.overflow !== 1'b0 || bt.awfull !== 1'b0 || bf.rdata !== 32'd0) begin failures++; $display("FAIL ar_flags got=ovf%b awfull%b reg%0h exp=ovf0 awfull0 reg0", bt.overflow, bt.awfull, bf.rdata); end
    winc = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    winc = 1'b1; wdata = 32'hB; tick(); winc = 1'b0;
    rinc = 1'b1;
    checks++; if (bt.rdata !== 32'hB || bt.fill !== 5'd1) begin failures++; $display("FAIL ar_after_ft got=%0h fill%0d exp=b fill1", bt.rdata, bt.fill); end
    tick(); rinc = 1'b0;
    checks++; if (bf.rdata !== 32'hB || bt.rempty !== 1'b1) begin failures++; $display("FAIL ar_after_reg got=%0h rempty%b exp=b rempty1", bf.rdata, bt.rempty); end
  endtask

  initial begin
    tick(); tick();
    test_reset();
    rst_n = 1'b1;
    tick();
    test_stream();
    test_full();
    test_thresholds();
    test_underflow();
    test_flush();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/sync_fifo.md
Name: sync_fifo

Overview:
- Single-clock FIFO, parametrised in data width and depth.
- Successor to the dual-clock FIFO for same-domain buffering.
- Adds runtime-programmable almost-full/almost-empty thresholds, a fill-level output, synchronous flush, and sticky overflow/underflow error flags.
- Keeps the fall-through and registered read modes.

Parameters:
- DSIZE, 32, data width in bits.
- ASIZE, 4, address width; depth DEPTH = 2**ASIZE.
- FALLTHROUGH, "TRUE":
  - "TRUE": rdata shows the head entry combinationally.
  - "FALSE": rdata is registered, with 1-cycle read latency.

Ports:
- clk  input  1  clock; all logic is on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- flush  input  1  synchronous clear of FIFO contents and error flags.
- winc  input  1  write request.
- wdata  input  DSIZE  write data.
- wfull  output  1  FIFO full.
- awfull  output  1  almost full.
- awfull_th  input  ASIZE  almost-full margin.
- rinc  input  1  read request.
- rdata  output  DSIZE  read data.
- rempty  output  1  FIFO empty.
- arempty  output  1  almost empty.
- arempty_th  input  ASIZE  almost-empty level.
- fill  output  ASIZE+1  current entry count, 0..DEPTH.
- overflow  output  1  sticky: a write was attempted while full.
- underflow  output  1  sticky: a read was attempted while empty.

Behaviour:
- Storage and pointers:
  - Storage is a DEPTH x DSIZE memory. Memory contents are not reset.
  - Write and read pointers are ASIZE+1 bits binary. The extra MSB distinguishes full from empty.
  - Pointers wrap naturally from DEPTH*2-1 to 0.
- Acceptance:
  - Write is accepted when winc && !wfull. Read is accepted when rinc && !rempty.
  - Acceptance uses the flag values present before the edge.
- Simultaneous events:
  - Write+read while full: the read is accepted, the write is rejected, overflow sets, fill goes to DEPTH-1.
  - Write+read while empty: the write is accepted, the read is rejected, underflow sets, fill goes to 1.
  - Write+read otherwise: both are accepted and fill is unchanged.
- Flag timing:
  - fill, wfull, rempty, awfull and arempty are registered. They reflect the state after the edge.
  - Latency is 1 cycle from an accepted write to rempty deasserting.
- Flag definitions:
  - wfull = (fill == DEPTH).
  - rempty = (fill == 0).
  - awfull = (fill >= DEPTH - awfull_th). This includes full. With awfull_th = 0, awfull equals wfull.
  - arempty = (fill != 0) && (fill <= arempty_th). With arempty_th = 0, arempty never asserts.
  - Threshold inputs are quasi-static. A change is reflected at the next edge.
- FALLTHROUGH="TRUE":
  - rdata = mem[rptr] combinationally. It is valid whenever !rempty and don't-care while empty.
  - An accepted rinc pops the entry; the next entry appears after the edge.
- FALLTHROUGH="FALSE":
  - On an accepted read, rdata <= mem[rptr] at that edge and holds until the next accepted read.
  - A rejected read leaves rdata unchanged.
- Error flags:
  - overflow and underflow stay set until flush or reset.
  - They do not block further operation.
- flush (synchronous):
  - Pointers go to 0: fill=0, rempty=1, wfull=0, awfull=0, arempty=0.
  - overflow and underflow clear. Registered rdata goes to 0.
  - winc and rinc in the same cycle are ignored and do not raise error flags.
- Reset (async assert; deassertion assumed synchronous to clk):
  - fill=0, rempty=1, wfull=0, awfull=0, arempty=0, overflow=0, underflow=0.
  - rdata=0 in "FALSE" mode.
  - Reset asserted mid-operation discards all contents immediately.

Test Plan:
- Idle after reset -> rempty=1, wfull=0, awfull=0, arempty=0, fill=0, overflow=underflow=0.
- Write 0..9 on consecutive cycles, then read 10 consecutive -> rdata sequence 0..9 in order, fill returns to 0, rempty=1.
  - "TRUE": data is visible in the same cycle as rinc.
  - "FALSE": data is visible the cycle after the accepted rinc.
- Write 16 entries (ASIZE=4), then a 17th write -> wfull=1 and fill=16 after the 16th; the 17th is dropped and overflow=1.
  - Then one simultaneous write+read while full -> fill=15 and the read returns 0.
- awfull_th=3, arempty_th=2:
  - Write 2 -> arempty=1.
  - Write a 3rd -> arempty=0.
  - Continue to fill=13 -> awfull=1; at fill=12, awfull=0.
- rinc while empty, with and without a simultaneous winc -> underflow=1 in both cases; the simultaneous winc is still stored (fill=1).
- Mid-stream: fill=8, overflow=1, then assert flush with winc=1 -> the next cycle shows fill=0, rempty=1, overflow=0.
  - Subsequent write 0xA then read -> 0xA.
  - Repeat using rst_n asynchronously mid-burst -> same reset values.
